fpga_cfg_controller: RTL and testbench
======================================

Name: fpga_cfg_controller

Overview:
FPGA-side controller that sits directly upstream of the chip backend. It sequences the chip power-on reset (o_resetbAll) and waits for the backend's ready handshake. It then serially shifts configuration frames (gain, bias, RO enable, etc.) into the backend over o_sclk/o_sdout. New frames come from a host-side valid/ready interface; a parameter default frame is sent automatically after every reset sequence.

Parameters:
CFG_W, 16, configuration frame width in bits (MSB first on the wire)
CFG_DEFAULT, 16'h0001, frame sent automatically after each reset sequence
SCLK_DIV, 2, i_mainclk cycles per o_sclk half-period (>=1)
RST_CYCLES, 8, i_mainclk cycles o_resetbAll is held low
READY_TIMEOUT, 1024, cycles allowed for i_ready to rise after reset release
GAP_CYCLES, 4, idle cycles with o_sclk low between frames

Ports:
i_mainclk  input  1  system clock, shared with the backend
i_resetbFPGA  input  1  asynchronous active-low reset
i_ready  input  1  backend ready, synchronous to i_mainclk
i_soft_rst  input  1  one-cycle pulse: re-run the chip reset sequence
i_cfg_data  input  CFG_W  frame to transmit
i_cfg_valid  input  1  host frame valid
o_cfg_ready  output  1  controller accepts a frame this cycle
o_resetbAll  output  1  chip-wide active-low reset
o_sclk  output  1  serial config clock
o_sdout  output  1  serial config data
o_busy  output  1  high in every state except IDLE
o_err  output  1  sticky ready-timeout flag

Behaviour:
- One clock (i_mainclk). Reset is asynchronous and active-low (i_resetbFPGA). All outputs are registered.
- Values while i_resetbFPGA is low: o_resetbAll=0, o_sclk=0, o_sdout=0, o_cfg_ready=0, o_busy=1, o_err=0, state=RST_HOLD, counters=0.
- RST_HOLD:
  - o_resetbAll=0 for exactly RST_CYCLES cycles after reset deassertion or entry.
  - Then o_resetbAll=1 and go to WAIT_READY.
- WAIT_READY:
  - Count cycles. When i_ready=1, load CFG_DEFAULT into the shift register and go to SHIFT.
  - If the count reaches READY_TIMEOUT, set o_err=1 (sticky until i_resetbFPGA) and return to RST_HOLD (retry).
- SHIFT:
  - On entry, o_sdout = frame MSB and o_sclk=0.
  - Every SCLK_DIV cycles o_sclk toggles.
  - o_sdout updates only on the cycle o_sclk falls; it is stable across every rising edge, where the backend samples.
  - Exactly CFG_W rising edges per frame. Frame duration = 2*SCLK_DIV*CFG_W cycles.
  - After the last falling edge, o_sdout=0 and go to GAP.
- GAP: o_sclk=0 and o_sdout=0 for GAP_CYCLES cycles, then go to IDLE.
- IDLE:
  - o_cfg_ready=1, o_busy=0.
  - When i_cfg_valid & o_cfg_ready, capture i_cfg_data and go to SHIFT. o_cfg_ready drops the following cycle.
- o_cfg_ready is 1 only in IDLE. A valid held while not ready is not captured, and the host must hold data until accepted.
- i_ready falls in IDLE or GAP: go to WAIT_READY with no frame pending. The next frame after ready returns is CFG_DEFAULT.
- i_ready falls during SHIFT: abort the frame, force o_sclk=0 and o_sdout=0, go to WAIT_READY.
- i_soft_rst in any state: go to RST_HOLD next cycle and abort any frame. o_sclk/o_sdout go to 0 and o_resetbAll goes to 0 on that cycle. i_soft_rst has priority over i_cfg_valid in the same cycle.
- i_soft_rst while in RST_HOLD restarts the hold count.
- Counters are sized with $clog2 of their limits. Bit counter runs CFG_W-1 down to 0 with no wrap beyond 0.

Decomposition:
- Shared package fpga_ctrl_pkg holds the state enum (RST_HOLD, WAIT_READY, SHIFT, GAP, IDLE) and frame field constants: GAIN_LSB=0, GAIN_W=3, IBIAS2X_BIT=3, ENRO_BIT=4.
- One natural sub-module: cfg_shifter. It contains the SCLK_DIV divider, shift register and bit counter. Ports: load, abort, data, sclk, sdout, done.

Test Plan:
- Reset then i_ready forced high at cycle 20 -> o_resetbAll low exactly 8 cycles. Next, 16 sclk rising edges shift 16'h0001 MSB first (15 zeros, then a 1). Frame takes 64 cycles; then a 4-cycle gap, then o_cfg_ready=1.
- In IDLE, i_cfg_valid with 16'hA5C3 -> o_cfg_ready drops next cycle. Bits sampled on sclk rise equal 1010010111000011, and o_sdout never changes while o_sclk=1.
- i_ready held low -> o_err=1 after 1024 WAIT_READY cycles, o_resetbAll pulses low 8 cycles again, and o_err stays 1 after the retry succeeds.
- i_ready dropped after 5 sclk rises of a frame -> o_sclk and o_sdout go to 0 next cycle. When i_ready returns, a full CFG_DEFAULT frame is sent.
- i_soft_rst and i_cfg_valid in the same IDLE cycle -> frame not accepted, o_resetbAll=0 for 8 cycles, then the default frame is resent.
- i_resetbFPGA asserted mid-SHIFT -> all outputs reach their reset values immediately (asynchronous), without waiting for a clock edge.

Source files
------------

// File: rtl/fpga_ctrl_pkg.sv
// Shared types and constants for the FPGA-side chip configuration controller.
// Field positions describe the layout of a configuration frame as seen by the backend.
package fpga_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    WAIT_READY = 3'd1,
    SHIFT      = 3'd2,
    GAP        = 3'd3,
    IDLE       = 3'd4
  } state_t;

  localparam int GAIN_LSB    = 0;
  localparam int GAIN_W      = 3;
  localparam int IBIAS2X_BIT = 3;
  localparam int ENRO_BIT    = 4;

  // Counter width for a limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/fpga_cfg_controller_cfg_shifter.sv
// Serialises one configuration frame MSB first: sclk divider, shift register and bit counter.
// sdout changes only together with a falling sclk, so it is stable at every rising edge.
module cfg_shifter
  import fpga_ctrl_pkg::*;
#(
  parameter int CFG_W    = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             abort,
  input  logic [CFG_W-1:0] data,
  output logic             sclk,
  output logic             sdout,
  output logic             done
);

  localparam int DIV_W = cnt_width(SCLK_DIV);
  localparam int BIT_W = cnt_width(CFG_W);

  logic [CFG_W-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             active;
  logic             tick;

  assign tick = active && (div_cnt == DIV_W'(SCLK_DIV - 1));
  // Strobe on the cycle whose edge produces the final falling sclk.
  assign done = tick && sclk && (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdout   <= 1'b0;
    end else if (abort) begin
      active  <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      sdout   <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      sdout   <= data[CFG_W-1];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= BIT_W'(CFG_W - 1);
      active  <= 1'b1;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          if (bit_cnt == '0) begin
            active <= 1'b0;
            sdout  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            shreg   <= shreg << 1;
            sdout   <= shreg[CFG_W-2];
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_cfg_controller.sv
// Chip power-on reset sequencing, backend ready handshake and serial frame delivery.
// Host handshake: a frame transfers on a cycle where i_cfg_valid and o_cfg_ready are both high.
module fpga_cfg_controller
  import fpga_ctrl_pkg::*;
#(
  parameter int               CFG_W         = 16,
  parameter logic [CFG_W-1:0] CFG_DEFAULT   = 16'h0001,
  parameter int               SCLK_DIV      = 2,
  parameter int               RST_CYCLES    = 8,
  parameter int               READY_TIMEOUT = 1024,
  parameter int               GAP_CYCLES    = 4
) (
  input  logic             i_mainclk,
  input  logic             i_resetbFPGA,
  input  logic             i_ready,
  input  logic             i_soft_rst,
  input  logic [CFG_W-1:0] i_cfg_data,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  output logic             o_resetbAll,
  output logic             o_sclk,
  output logic             o_sdout,
  output logic             o_busy,
  output logic             o_err,
  output state_t           dbg_state
);

  localparam int CNT_MAX_A = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (READY_TIMEOUT > CNT_MAX_A) ? READY_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = cnt_width(CNT_MAX);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             load, abort, done, timeout;
  logic [CFG_W-1:0] load_data;

  always_comb begin
    state_d   = state;
    cnt_d     = '0;
    load      = 1'b0;
    abort     = 1'b0;
    timeout   = 1'b0;
    load_data = i_cfg_data;
    if (i_soft_rst) begin
      state_d = RST_HOLD;
      abort   = 1'b1;
    end else begin
      case (state)
        RST_HOLD: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_READY;
          else cnt_d = cnt + 1'b1;
        end
        WAIT_READY: begin
          if (i_ready) begin
            state_d   = SHIFT;
            load      = 1'b1;
            load_data = CFG_DEFAULT;
          end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
            state_d = RST_HOLD;
            timeout = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!i_ready) begin
            state_d = WAIT_READY;
            abort   = 1'b1;
          end else if (done) begin
            state_d = GAP;
          end
        end
        GAP: begin
          if (!i_ready) state_d = WAIT_READY;
          else if (cnt == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
          else cnt_d = cnt + 1'b1;
        end
        IDLE: begin
          if (!i_ready) begin
            state_d = WAIT_READY;
          end else if (i_cfg_valid && o_cfg_ready) begin
            state_d = SHIFT;
            load    = 1'b1;
          end
        end
        default: state_d = RST_HOLD;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
    if (!i_resetbFPGA) begin
      state       <= RST_HOLD;
      cnt         <= '0;
      o_resetbAll <= 1'b0;
      o_cfg_ready <= 1'b0;
      o_busy      <= 1'b1;
      o_err       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      o_resetbAll <= (state_d != RST_HOLD);
      o_cfg_ready <= (state_d == IDLE);
      o_busy      <= (state_d != IDLE);
      o_err       <= o_err | timeout;
    end
  end

  assign dbg_state = state;

  cfg_shifter #(
    .CFG_W   (CFG_W),
    .SCLK_DIV(SCLK_DIV)
  ) u_shifter (
    .clk  (i_mainclk),
    .rst_n(i_resetbFPGA),
    .load (load),
    .abort(abort),
    .data (load_data),
    .sclk (o_sclk),
    .sdout(o_sdout),
    .done (done)
  );

endmodule

// File: tb/tb_fpga_cfg_controller.sv
// Directed bench for fpga_cfg_controller: reset sequencing, frame shifting, gap,
// ready timeout, ready loss mid-frame, soft reset and asynchronous reset.
module tb_fpga_cfg_controller;
  import fpga_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_in;
  logic        soft_rst;
  logic [15:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        resetb_all;
  logic        sclk;
  logic        sdout;
  logic        busy;
  logic        err;
  state_t      dbg_state;

  int total  = 0;
  int passed = 0;

  fpga_cfg_controller dut (
    .i_mainclk   (clk),
    .i_resetbFPGA(rst_n),
    .i_ready     (ready_in),
    .i_soft_rst  (soft_rst),
    .i_cfg_data  (cfg_data),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .o_resetbAll (resetb_all),
    .o_sclk      (sclk),
    .o_sdout     (sdout),
    .o_busy      (busy),
    .o_err       (err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Follows one frame while the DUT is in SHIFT, sampling sdout at each sclk rise.
  task automatic capture(output logic [15:0] bits, output int rises, output int cycles,
                         output int stable);
    logic prev_sclk;
    logic held;
    bits = '0; rises = 0; cycles = 0; stable = 1;
    prev_sclk = sclk;
    held = sdout;
    while (dbg_state == SHIFT && cycles < 200) begin
      step();
      cycles++;
      if (sclk && !prev_sclk) begin
        rises++;
        bits = {bits[14:0], sdout};
        held = sdout;
      end else if (sclk && sdout !== held) begin
        stable = 0;
      end
      prev_sclk = sclk;
    end
  endtask

  // Counts cycles until the controller is ready for a host frame; checks the line stays quiet.
  task automatic wait_gap(output int n, output int clean);
    n = 0; clean = 1;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
      if (sclk !== 1'b0 || sdout !== 1'b0) clean = 0;
    end
  endtask

  task automatic count_reset_low(output int n);
    n = 0;
    while (!resetb_all && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_bits);
    logic [15:0] bits;
    int rises, cycles, stable, gap, clean;
    capture(bits, rises, cycles, stable);
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_rises"}, rises, 16);
    chk({tag, "_cycles"}, cycles, 64);
    chk({tag, "_stable"}, stable, 1);
    wait_gap(gap, clean);
    chk({tag, "_gap"}, gap, 4);
    chk({tag, "_gap_quiet"}, clean, 1);
  endtask

  task automatic send(input logic [15:0] d);
    cfg_data  = d;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    rst_n = 1'b0; ready_in = 1'b0; soft_rst = 1'b0; cfg_data = '0; cfg_valid = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_resetb", resetb_all, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdout", sdout, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    chk("rst_state", 32'(dbg_state), 32'(RST_HOLD));

    // Power-on hold, then ready arrives and the default frame goes out
    rst_n = 1'b1;
    count_reset_low(n);
    chk("por_hold_len", n, 8);
    chk("por_wait_state", 32'(dbg_state), 32'(WAIT_READY));
    repeat (5) step();
    ready_in = 1'b1;
    step();
    chk("def_state", 32'(dbg_state), 32'(SHIFT));
    chk("def_first_sdout", sdout, 0);
    check_frame("def", 16'h0001);
    chk("idle_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

    // Host frame
    send(16'hA5C3);
    chk("host_ready_drop", cfg_ready, 0);
    chk("host_state", 32'(dbg_state), 32'(SHIFT));
    chk("host_msb", sdout, 1);
    check_frame("host", 16'hA5C3);

    // Ready lost after 5 sclk rises
    send(16'hFFFF);
    r = 0; n = 0;
    begin
      logic prev;
      prev = sclk;
      while (r < 5 && n < 100) begin
        step();
        n++;
        if (sclk && !prev) r++;
        prev = sclk;
      end
    end
    chk("abort_pre_sdout", sdout, 1);
    ready_in = 1'b0;
    step();
    chk("abort_sclk", sclk, 0);
    chk("abort_sdout", sdout, 0);
    chk("abort_state", 32'(dbg_state), 32'(WAIT_READY));
    ready_in = 1'b1;
    step();
    chk("abort_resume_state", 32'(dbg_state), 32'(SHIFT));
    check_frame("abort_def", 16'h0001);

    // Soft reset wins over a valid frame in the same cycle
    cfg_data = 16'h1234; cfg_valid = 1'b1; soft_rst = 1'b1;
    step();
    cfg_valid = 1'b0; soft_rst = 1'b0;
    chk("srst_resetb", resetb_all, 0);
    chk("srst_state", 32'(dbg_state), 32'(RST_HOLD));
    chk("srst_cfg_ready", cfg_ready, 0);
    count_reset_low(n);
    chk("srst_hold_len", n, 8);
    step();
    check_frame("srst_def", 16'h0001);

    // Soft reset during the hold restarts the count
    soft_rst = 1'b1; step(); soft_rst = 1'b0;
    repeat (3) step();
    soft_rst = 1'b1; step(); soft_rst = 1'b0;
    count_reset_low(n);
    chk("srst_restart_len", n, 8);
    step();
    check_frame("srst2_def", 16'h0001);

    // Ready timeout, retry and sticky error
    ready_in = 1'b0;
    step();
    chk("to_wait_state", 32'(dbg_state), 32'(WAIT_READY));
    chk("to_err_before", err, 0);
    n = 0;
    while (!err && n < 2000) begin
      step();
      n++;
    end
    chk("to_cycles", n, 1024);
    chk("to_resetb_low", resetb_all, 0);
    count_reset_low(n);
    chk("to_retry_hold_len", n, 8);
    ready_in = 1'b1;
    step();
    check_frame("to_def", 16'h0001);
    chk("to_err_sticky", err, 1);

    // Asynchronous reset in the middle of a frame
    send(16'hFFFF);
    repeat (3) step();
    chk("async_pre_sclk", sclk, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_resetb", resetb_all, 0);
    chk("async_sclk", sclk, 0);
    chk("async_sdout", sdout, 0);
    chk("async_busy", busy, 1);
    chk("async_cfg_ready", cfg_ready, 0);
    chk("async_err", err, 0);
    chk("async_state", 32'(dbg_state), 32'(RST_HOLD));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
